rx_buffer_ctrl: RTL and testbench

Circular-buffer controller that sequences one buffer_memory instance (32-bit words, 14-bit addresses) as a packet FIFO between the RX packet parser (producer) and the TCP/UDP payload consumer. Writes are speculative until the producer commits the packet or drops it, for example on a checksum failure. Only committed words are visible to the consumer. The block owns all buffer_memory address, enable and data ports; memory reset is wired separately.

---
 rtl/rx_buffer_ctrl.sv | 144 ++++++++++++++
 tb/tb_rx_buffer_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_buffer_ctrl.sv
// rx_buffer_ctrl: circular packet FIFO controller in front of one buffer_memory.
// Producer words land speculatively at wr_ptr. A commit publishes them by moving
// cm_ptr, and a drop rewinds wr_ptr to cm_ptr. The consumer only sees words
// below cm_ptr. Read data comes back from the memory one cycle after mem_rd_en.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. wr_ready depends only on registered pointers,
// never on wr_valid. rd_valid, once high, stays high with rd_data stable until
// rd_ready is seen.
module rx_buffer_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  wr_commit,
  input  logic                  wr_drop,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   used_words,
  output logic [ADDR_WIDTH:0]   free_words,
  output logic [ADDR_WIDTH-1:0] mem_addr_wr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_rd,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [1:0]            dbg_state
);

  localparam int PW = ADDR_WIDTH + 1;
  // DEPTH as a pointer-width value: only the wrap bit set.
  localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } rd_state_e;

  rd_state_e             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [PW-1:0]         avail;
  logic                  wr_accept;
  logic                  rd_issue;

  // Occupancy counts every slot not yet handed to the read port, so a slot is
  // reusable as soon as its read has been issued.
  assign used_words = wr_ptr_q - rd_ptr_q;
  assign free_words = DEPTH_C - used_words;
  assign avail      = cm_ptr_q - rd_ptr_q;
  assign wr_ready   = (used_words != DEPTH_C);

  // Reset is folded in so the memory is never written while the block is held in reset.
  assign wr_accept   = wr_valid & wr_ready & ~wr_drop & reset;
  assign mem_wr_en   = wr_accept;
  assign mem_addr_wr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign mem_data_in = wr_data;

  assign mem_rd_en   = rd_issue;
  assign mem_addr_rd = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign dbg_state   = state_q;

  // Write side: advance on accept, publish on commit, rewind on drop (drop wins).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    if (wr_drop) begin
      wr_ptr_d = cm_ptr_q;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + ONE_C;
      if (wr_commit) cm_ptr_d = wr_ptr_q + (wr_accept ? ONE_C : '0);
    end
  end

  // Read FSM: issue a read, capture the returned word, hold it until taken.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_issue   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (avail != '0) begin
          rd_issue = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_data_d  = mem_data_out;
        rd_valid_d = 1'b1;
        state_d    = ST_VALID;
      end
      ST_VALID: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (avail != '0) begin
            rd_issue = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d    = ST_EMPTY;
        rd_valid_d = 1'b0;
      end
    endcase
    if (rd_issue) rd_ptr_d = rd_ptr_q + ONE_C;
  end

  // State and pointer registers; reset discards all contents and the held word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Bench for rx_buffer_ctrl with a 16-word buffer and a behavioural buffer_memory.
module tb_rx_buffer_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          wr_commit;
  logic          wr_drop;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [AW:0]   used_words;
  logic [AW:0]   free_words;
  logic [AW-1:0] mem_addr_wr;
  logic [DW-1:0] mem_data_in;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr_rd;
  logic          mem_rd_en;
  logic [DW-1:0] mem_data_out;
  logic [1:0]    dbg_state;

  rx_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_commit(wr_commit), .wr_drop(wr_drop),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .used_words(used_words), .free_words(free_words),
    .mem_addr_wr(mem_addr_wr), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
    .mem_addr_rd(mem_addr_rd), .mem_rd_en(mem_rd_en), .mem_data_out(mem_data_out),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // buffer_memory model: synchronous write, registered read data
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr_wr] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= mem[mem_addr_rd];
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] spec_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [AW:0]   m_wr = '0;
  logic [AW:0]   m_cm = '0;
  int            m_wraps = 0;
  int            d_wraps = 0;
  logic [AW-1:0] last_wa = '0;
  logic          wa_seen = 1'b0;
  logic          last_acc;

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model of the write side, updated once per driven cycle.
  task automatic model_update(input logic wv, input logic [DW-1:0] wd, input logic wc, input logic wdr);
    logic acc;
    acc = wv && !wdr && wr_ready;
    last_acc = acc;
    chk("wr_en", mem_wr_en, acc);
    if (acc) begin
      chk("wr_addr", mem_addr_wr, m_wr[AW-1:0]);
      chk("wr_data", mem_data_in, wd);
      spec_q.push_back(wd);
      if (&m_wr[AW-1:0]) m_wraps++;
      m_wr = m_wr + 1'b1;
    end
    if (wdr) begin
      spec_q.delete();
      m_wr = m_cm;
    end else if (wc) begin
      foreach (spec_q[j]) exp_q.push_back(spec_q[j]);
      spec_q.delete();
      m_cm = m_wr;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic wc,
                       input logic wdr, input logic rr);
    @(posedge clk);
    #1;
    wr_valid  = wv;
    wr_data   = wd;
    wr_commit = wc;
    wr_drop   = wdr;
    rd_ready  = rr;
    #1;
    model_update(wv, wd, wc, wdr);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    do begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n++;
    end while ((exp_q.size() != 0 || rd_valid) && n < 300);
    chk({nm, "_drained"}, {31'd0, (exp_q.size() == 0 && !rd_valid)}, 1);
    chk({nm, "_used"}, used_words, 0);
    chk({nm, "_free"}, free_words, DEPTH);
  endtask

  // Consumer-side monitor: every handshake pops one expected word.
  always @(negedge clk) begin
    if (reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_word", rd_data, 32'hFFFF_FFFF ^ rd_data);
      end else begin
        chk("sb_data", rd_data, exp_q.pop_front());
      end
    end
    if (reset && mem_wr_en) begin
      if (wa_seen && last_wa == AW'(DEPTH - 1) && mem_addr_wr == '0) d_wraps++;
      last_wa = mem_addr_wr;
      wa_seen = 1'b1;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          wc;
    logic          wdr;
    logic          rr;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic [AW:0]   e_used;
    logic          e_wrdy;
    logic          e_mwe;
    logic          e_mre;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int guard;
    int d0;
    int m0;
    logic [DW-1:0] first_w;

    // inputs / expected outputs, one row per cycle
    tbl[0]  = '{1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'hEF01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    5'd1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h2345, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    5'd2, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    5'd3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    5'd3, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    5'd3, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    5'd2, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'hABCD, 5'd2, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    5'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'hEF01, 5'd1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    5'd0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'h2345, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b1, 1'b0, 1'b0};

    // reset, checked before any clock edge
    reset = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_commit = 1'b0; wr_drop = 1'b0; rd_ready = 1'b0;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_used", used_words, 0);
    chk("rst_free", free_words, DEPTH);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // speculative write, commit latency, 1 read per 2 cycles
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].wv, tbl[k].wd, tbl[k].wc, tbl[k].wdr, tbl[k].rr);
      chk($sformatf("t1_rv_%0d", k), rd_valid, tbl[k].e_rv);
      if (tbl[k].e_rv) chk($sformatf("t1_rd_%0d", k), rd_data, tbl[k].e_rd);
      chk($sformatf("t1_used_%0d", k), used_words, tbl[k].e_used);
      chk($sformatf("t1_free_%0d", k), free_words, DEPTH - tbl[k].e_used);
      chk($sformatf("t1_wrdy_%0d", k), wr_ready, tbl[k].e_wrdy);
      chk($sformatf("t1_mwe_%0d", k), mem_wr_en, tbl[k].e_mwe);
      chk($sformatf("t1_mre_%0d", k), mem_rd_en, tbl[k].e_mre);
    end

    // drop discards only uncommitted words; a word presented with drop is not written
    drive(1'b1, 32'h1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2222, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h3333, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h4444, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h5555, 1'b0, 1'b1, 1'b0);
    chk("t2_drop_no_write", mem_wr_en, 0);
    wait_drain("t2");

    // full buffer: 16 words fill it, the 17th is ignored
    for (int k = 0; k < DEPTH; k++) drive(1'b1, 32'h100 + k, (k == DEPTH - 1), 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("t3_full_ready", wr_ready, 0);
    chk("t3_full_used", used_words, DEPTH);
    chk("t3_full_free", free_words, 0);
    chk("t3_17th_ignored", mem_wr_en, 0);
    chk("t3_read_issue", mem_rd_en, 1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t3_ready_back", wr_ready, 1);
    chk("t3_used_after_issue", used_words, DEPTH - 1);
    wait_drain("t3");

    // streaming with wrap, commit every 5 words, consumer always ready
    d0 = d_wraps;
    m0 = m_wraps;
    i = 0;
    guard = 0;
    while (i < 40 && guard < 1000) begin
      drive(1'b1, DW'(i), (i % 5 == 4), 1'b0, 1'b1);
      if (last_acc) i++;
      guard++;
    end
    chk("t4_all_sent", i, 40);
    wait_drain("t4");
    chk("t4_addr_wraps", d_wraps - d0, m_wraps - m0);

    // consumer stall: held word stays stable, no reads issued
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hA5A5_0002, 1'b1, 1'b0, 1'b0);
    first_w = exp_q[0];
    guard = 0;
    do begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      guard++;
    end while (!rd_valid && guard < 20);
    chk("t5_valid", rd_valid, 1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t5_hold_%0d", k), rd_data, first_w);
      chk($sformatf("t5_no_issue_%0d", k), mem_rd_en, 0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_release_issue", mem_rd_en, 1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_gap", rd_valid, 0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_next_valid", rd_valid, 1);
    chk("t5_next_data", rd_data, 32'hA5A5_0002);
    wait_drain("t5");

    // asynchronous reset between edges, mid-read and mid-packet
    drive(1'b1, 32'hC001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC002, 1'b1, 1'b0, 1'b0);
    guard = 0;
    do begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      guard++;
    end while (!rd_valid && guard < 20);
    chk("t6_valid_before", rd_valid, 1);
    drive(1'b1, 32'hC003, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC004, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_used", used_words, 0);
    chk("t6_free", free_words, DEPTH);
    chk("t6_mem_wr_en", mem_wr_en, 0);
    chk("t6_mem_rd_en", mem_rd_en, 0);
    exp_q.delete();
    spec_q.delete();
    m_wr = '0;
    m_cm = '0;
    wr_valid = 1'b0; wr_commit = 1'b0; wr_drop = 1'b0; rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("t6_no_old_%0d", k), rd_valid, 0);
    end
    chk("t6_used_after", used_words, 0);
    drive(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b1);
    wait_drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
